// File: rtl/reg_file_dec.sv
// 32-entry register file with one-hot write decode, r0 hard-wired to zero and a committed-write counter.
// Optional write-through bypass on all read ports when REGFILE_BYPASS_EN is defined.
module reg_file_dec #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [4:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [4:0]    dbg_ra,
  output logic [DW-1:0] dbg_rd,
  output logic [31:0]   wr_cnt
);

  logic [DW-1:0] regs [32];
  logic [31:1]   wstb;
  logic [31:0]   cnt;
  logic          commit;

  assign commit = we && (wa != 5'd0);

  always_comb begin
    wstb = '0;
    for (int i = 1; i < 32; i++) begin
      wstb[i] = we && (wa == 5'(i));
    end
  end

  // regs[0] is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wstb[i]) regs[i] <= wd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (commit) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign wr_cnt = cnt;

  function automatic logic [DW-1:0] rd_sel(input logic [4:0] a);
    logic [DW-1:0] v;
    v = (a == 5'd0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
    if (commit && !rst && (a == wa)) v = wd;
`endif
    return v;
  endfunction

  always_comb begin
    rd1    = rd_sel(ra1);
    rd2    = rd_sel(ra2);
    dbg_rd = rd_sel(dbg_ra);
  end

endmodule

// File: tb/tb_reg_file_dec.sv
// Directed bench for reg_file_dec: vector table plus hand sequences for reset, bypass, wrap and sweep.
module tb_reg_file_dec;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          we;
  logic [4:0]    wa;
  logic [DW-1:0] wd;
  logic [4:0]    ra1, ra2, dbg_ra;
  logic [DW-1:0] rd1, rd2, dbg_rd;
  logic [31:0]   wr_cnt;

  int n_chk;
  int n_fail;
  logic [31:0] exp_cnt;

  reg_file_dec #(.DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .dbg_ra (dbg_ra),
    .dbg_rd (dbg_rd),
    .wr_cnt (wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dra;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (a != 5'd0) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
    ra1 = 5'd5; ra2 = 5'd9; dbg_ra = 5'd31;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rd2", rd2, 32'h0);
    chk("reset_dbg", dbg_rd, 32'h0);
    chk("reset_cnt", wr_cnt, 32'h0);
    rst = 1'b0;

    // Asynchronous reset with no clock edge clears r5 and the counter
    wr(5'd5, 32'h1234);
    chk("pre_async_r5", rd1, 32'h1234);
    chk("pre_async_cnt", wr_cnt, exp_cnt);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_r5", rd1, 32'h0);
    chk("async_cnt", wr_cnt, 32'h0);
    #1;
    rst = 1'b0;
    exp_cnt = 0;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd1};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'd1};
    tbl[2] = '{1'b0, 5'd9,  32'h12345678, 5'd9,  5'd5,  5'd9,  32'h0,        32'hDEADBEEF, 32'h0,        32'd1};
    tbl[3] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd2};
    tbl[4] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd9,  5'd5,  32'h80000001, 32'hA5A5A5A5, 32'hDEADBEEF, 32'd3};
    tbl[5] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd31, 5'd0,  32'h0,        32'h80000001, 32'h0,        32'd4};
    tbl[6] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  5'd9,  32'h80000001, 32'h0,        32'hA5A5A5A5, 32'd4};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2; dbg_ra = tbl[i].dra;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, tbl[i].e2);
      chk($sformatf("vec%0d_dbg", i), dbg_rd, tbl[i].ed);
      chk($sformatf("vec%0d_cnt", i), wr_cnt, tbl[i].ec);
    end
    @(negedge clk);
    we = 1'b0;
    exp_cnt = 32'd4;

    // Same-cycle read of the register being written
    wr(5'd7, 32'h11);
    @(negedge clk);
    ra1 = 5'd7; ra2 = 5'd7; dbg_ra = 5'd7;
    we = 1'b1; wa = 5'd7; wd = 32'h22;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("samecyc_rd1", rd1, 32'h22);
    chk("samecyc_dbg", dbg_rd, 32'h22);
`else
    chk("samecyc_rd1", rd1, 32'h11);
    chk("samecyc_dbg", dbg_rd, 32'h11);
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("after_edge_rd1", rd1, 32'h22);
    chk("after_edge_rd2", rd2, 32'h22);
    chk("after_edge_cnt", wr_cnt, exp_cnt);

    // Write to r0 with a same-cycle read of r0 stays zero
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra2 = 5'd0;
    #1;
    chk("r0_samecyc_rd2", rd2, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("r0_rd2", rd2, 32'h0);
    chk("r0_cnt", wr_cnt, exp_cnt);

    // Counter wrap
    @(negedge clk);
    force dut.cnt = 32'hFFFFFFFF;
    #1;
    release dut.cnt;
    #1;
    chk("wrap_preload", wr_cnt, 32'hFFFFFFFF);
    wr(5'd3, 32'h33);
    chk("wrap_cnt", wr_cnt, 32'h0);
    ra1 = 5'd3;
    #1;
    chk("wrap_r3", rd1, 32'h33);

    // Reset coinciding with a write edge
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstcol_r3", rd1, 32'h0);
    chk("rstcol_cnt", wr_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    exp_cnt = 0;
    wr(5'd3, 32'h0000BEEF);
    chk("post_rst_r3", rd1, 32'h0000BEEF);
    chk("post_rst_cnt", wr_cnt, 32'd1);

    // Full sweep from a clean reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h100 + 32'(i));
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg_ra = 5'(i);
      #1;
      chk($sformatf("sweep_rd1_r%0d", i), rd1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      chk($sformatf("sweep_rd2_r%0d", i), rd2, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      chk($sformatf("sweep_dbg_r%0d", i), dbg_rd, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
    end
    chk("sweep_cnt", wr_cnt, 32'd31);
    chk("sweep_cnt_model", wr_cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_dec.md
REG_FILE_DEC -- requirements
Module: reg_file_dec

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 The block SHALL have port we, input, 1, the write enable for the current cycle.
REQ-005 The block SHALL have port wa, input, 5, the destination register number, as produced by the rt/rd selection mux.
REQ-006 The block SHALL have port wd, input, DW, the write data.
REQ-007 The block SHALL have ports ra1 and ra2, input, 5 each, the read addresses for port 1 and port 2.
REQ-008 The block SHALL have ports rd1 and rd2, output, DW each, the read data for port 1 and port 2.
REQ-009 The block SHALL have port dbg_ra, input, 5, the debug/display read address.
REQ-010 The block SHALL have port dbg_rd, output, DW, the debug read data.
REQ-011 The block SHALL have port wr_cnt, output, 32, the count of committed writes.

Function
REQ-012 The block SHALL decode wa into 31 one-hot write strobes for r1..r31; no strobe exists for r0.
REQ-013 On a rising clk edge with we=1 and wa!=0, the block SHALL load wd into register wa; all other registers hold their values.
REQ-014 A write with we=1 and wa=0 SHALL be discarded; r0 SHALL read as 0 on every port at all times.
REQ-015 Reads on rd1, rd2 and dbg_rd SHALL be combinational from their addresses, with zero-cycle latency.
REQ-016 After a write at edge N, the new value SHALL be visible on all read ports from edge N onward.
REQ-017 The same address on ra1, ra2 and dbg_ra simultaneously SHALL return identical data on all three ports.
REQ-018 wr_cnt SHALL increment by 1 on each edge where a write commits, i.e. we=1 and wa!=0.
REQ-019 wr_cnt SHALL be unchanged when we=0 or wa=0.
REQ-020 wr_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-021 Write data wider than needed SHALL NOT occur; wd SHALL be stored as the full DW bits, unmodified.

Reset
REQ-022 While rst=1, r1..r31 and wr_cnt SHALL be 0 immediately, independent of clk.
REQ-023 While rst=1, rd1, rd2 and dbg_rd SHALL read 0.
REQ-024 A write whose clock edge coincides with rst=1 SHALL be discarded and SHALL NOT be counted.
REQ-025 After rst deasserts, the first rising edge with we=1 and wa!=0 SHALL commit normally.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, the block SHALL add write-through bypass: when we=1, wa!=0 and raX==wa, rdX SHALL show wd combinationally in the same cycle; this applies to rd1, rd2 and dbg_rd.
REQ-027 Under REGFILE_BYPASS_EN, bypass SHALL be suppressed while rst=1 and when wa=0.
REQ-028 Without REGFILE_BYPASS_EN, a read of wa during the write cycle SHALL return the old stored value until the edge.

Verification
REQ-029 Reset: assert rst with no clock edge after r5=0x1234 -> r5 and wr_cnt read 0 immediately.
REQ-030 Basic write: we=1, wa=5, wd=0xDEADBEEF, then one edge with ra1=5 -> rd1=0xDEADBEEF and wr_cnt=1.
REQ-031 r0 write: we=1, wa=0, wd=0xFFFFFFFF, then edge with ra2=0 -> rd2=0 and wr_cnt unchanged.
REQ-032 Same-cycle read: r7=0x11, then we=1, wa=7, wd=0x22, ra1=7 before the edge -> rd1=0x22 with REGFILE_BYPASS_EN defined, 0x11 without it; 0x22 after the edge in both builds.
REQ-033 Wrap and reset collision: force wr_cnt=0xFFFFFFFF, commit one write -> wr_cnt=0. Then assert rst on the edge of a write to r3 -> r3=0 and wr_cnt=0.
REQ-034 Full sweep: write r1..r31 with value 0x100+i, then read all 32 addresses on ra1, ra2 and dbg_ra simultaneously -> all ports match 0x100+i for i>=1, 0 for i=0, and wr_cnt=31.
